// File: rtl/pwm_fader.sv
// Multi-channel PWM generator with a shared sawtooth/triangle fade engine.
// Duty values are double-buffered and only change at the PWM period boundary.
module pwm_fader #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 16,
  parameter int LVL_W    = 8,
  parameter int STEP_DIV = 16384
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*LVL_W-1:0] duty_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [LVL_W-1:0]          level,
  output logic                      period_tick
);

  localparam int PRESC_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(STEP_DIV - 1);
  localparam logic [LVL_W-1:0]   LVL_MAX   = {LVL_W{1'b1}};
  localparam logic [LVL_W-1:0]   LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [CNT_W-1:0]    pwm_cnt_r;
  logic [PRESC_W-1:0]  presc_r;
  logic [LVL_W-1:0]    level_r;
  dir_t                dir_r;
  logic [LVL_W-1:0]    duty_q_r [CHANNELS];
  logic [CHANNELS-1:0] pwm_out_r;
  logic                period_tick_r;

  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [LVL_W-1:0]    cnt_top_nxt_s;
  logic                wrap_s;
  logic                step_s;
  logic [PRESC_W-1:0]  presc_nxt_s;
  logic [LVL_W-1:0]    lvl_inc_s;
  logic [LVL_W-1:0]    lvl_dec_s;
  logic [LVL_W-1:0]    level_nxt_s;
  dir_t                dir_nxt_s;
  logic [LVL_W-1:0]    duty_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] pwm_nxt_s;

  assign cnt_nxt_s     = pwm_cnt_r + CNT_W'(1);
  assign cnt_top_nxt_s = cnt_nxt_s[CNT_W-1 -: LVL_W];
  assign wrap_s        = (pwm_cnt_r == {CNT_W{1'b1}});
  assign step_s        = (presc_r == PRESC_MAX);
  assign presc_nxt_s   = step_s ? {PRESC_W{1'b0}} : (presc_r + PRESC_W'(1));
  assign lvl_inc_s     = level_r + LVL_W'(1);
  assign lvl_dec_s     = level_r - LVL_W'(1);

  // Fade engine: next level and direction, advanced only on a prescaler step
  always_comb begin
    level_nxt_s = level_r;
    dir_nxt_s   = dir_r;
    if (step_s) begin
      case (mode)
        MODE_SAW: level_nxt_s = lvl_inc_s;
        MODE_TRI: begin
          // Endpoint checks on the current level keep a stale direction from overflowing
          if (dir_r == DIR_UP) begin
            if (level_r == LVL_MAX) begin
              level_nxt_s = lvl_dec_s;
              dir_nxt_s   = DIR_DOWN;
            end else begin
              level_nxt_s = lvl_inc_s;
              dir_nxt_s   = (lvl_inc_s == LVL_MAX) ? DIR_DOWN : DIR_UP;
            end
          end else begin
            if (level_r == LVL_ZERO) begin
              level_nxt_s = lvl_inc_s;
              dir_nxt_s   = DIR_UP;
            end else begin
              level_nxt_s = lvl_dec_s;
              dir_nxt_s   = (lvl_dec_s == LVL_ZERO) ? DIR_UP : DIR_DOWN;
            end
          end
        end
        MODE_HOLD:   level_nxt_s = level_r;
        MODE_STATIC: level_nxt_s = level_r;
        default:     level_nxt_s = level_r;
      endcase
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Shadow duty reload at the wrap and compare against the count about to be loaded
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_nxt_s[i] = duty_q_r[i];
      if (wrap_s) begin
        case (mode)
          MODE_STATIC: duty_nxt_s[i] = duty_in[i*LVL_W +: LVL_W];
          MODE_SAW, MODE_TRI, MODE_HOLD:
            duty_nxt_s[i] = ((i % 2) == 0) ? level_r : ~level_r;
          default: duty_nxt_s[i] = duty_q_r[i];
        endcase
      end else begin
        duty_nxt_s[i] = duty_q_r[i];
      end
      pwm_nxt_s[i] = en[i] & (cnt_top_nxt_s < duty_nxt_s[i]);
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt_r     <= {CNT_W{1'b0}};
      presc_r       <= {PRESC_W{1'b0}};
      level_r       <= {LVL_W{1'b0}};
      dir_r         <= DIR_UP;
      pwm_out_r     <= {CHANNELS{1'b0}};
      period_tick_r <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q_r[i] <= {LVL_W{1'b0}};
      end
    end else begin
      pwm_cnt_r     <= cnt_nxt_s;
      presc_r       <= presc_nxt_s;
      level_r       <= level_nxt_s;
      dir_r         <= dir_nxt_s;
      pwm_out_r     <= pwm_nxt_s;
      period_tick_r <= wrap_s;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q_r[i] <= duty_nxt_s[i];
      end
    end
  end

  assign pwm_out     = pwm_out_r;
  assign level       = level_r;
  assign period_tick = period_tick_r;

endmodule

// File: tb/tb_pwm_fader.sv
// Directed self-checking bench for pwm_fader (3 channels, 16-clock period, 2-bit levels).
module tb_pwm_fader;
  localparam int CH       = 3;
  localparam int CNT_W    = 4;
  localparam int LVL_W    = 2;
  localparam int STEP_DIV = 3;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic [CH-1:0]     en = 3'b111;
  logic [CH*LVL_W-1:0] duty_in = 6'd0;
  logic [CH-1:0]     pwm_out;
  logic [LVL_W-1:0]  level;
  logic              period_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int h0, h1, h2, t, first, bad;
  int tri_tab [17] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};

  pwm_fader #(
    .CHANNELS(CH), .CNT_W(CNT_W), .LVL_W(LVL_W), .STEP_DIV(STEP_DIV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .mode(mode), .en(en), .duty_in(duty_in),
    .pwm_out(pwm_out), .level(level), .period_tick(period_tick)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Samples one 16-cycle period starting at the current negedge; optional ch0 duty change
  task automatic measure(input int chg_idx, input logic [1:0] chg_val,
                         output int o0, output int o1, output int o2, output int ot);
    o0 = 0; o1 = 0; o2 = 0; ot = 0;
    for (int i = 0; i < 16; i++) begin
      o0 += (pwm_out[0] === 1'b1) ? 1 : 0;
      o1 += (pwm_out[1] === 1'b1) ? 1 : 0;
      o2 += (pwm_out[2] === 1'b1) ? 1 : 0;
      ot += (period_tick === 1'b1) ? 1 : 0;
      if (i == chg_idx) duty_in[1:0] = chg_val;
      @(negedge CLK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    duty_in = {2'd3, 2'd2, 2'd1};
    #2 RST_N = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_pwm", pwm_out, 3'b000);
    chk("rst_level", level, 0);
    chk("rst_tick", period_tick, 0);
    RST_N = 1'b1;

    // First period: duties still zero, first tick 16 cycles after release
    first = -1; bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (period_tick === 1'b1 && first < 0) first = k;
      if (k < 16 && pwm_out !== 3'b000) bad++;
    end
    chk("first_tick", first, 16);
    chk("p0_pwm_zero", bad, 0);
    chk("run_start", pwm_out, 3'b111);

    measure(-1, 2'd0, h0, h1, h2, t);
    chk("static_ch0", h0, 4);
    chk("static_ch1", h1, 8);
    chk("static_ch2", h2, 12);
    chk("static_ticks", t, 1);

    measure(5, 2'd3, h0, h1, h2, t);
    chk("glitch_cur_ch0", h0, 4);
    chk("glitch_cur_ch1", h1, 8);
    measure(-1, 2'd0, h0, h1, h2, t);
    chk("glitch_next_ch0", h0, 12);
    chk("glitch_next_ch1", h1, 8);
    chk("glitch_next_ch2", h2, 12);

    // Enable is not shadowed
    chk("en_start", pwm_out, 3'b111);
    en = 3'b101;
    @(negedge CLK);
    chk("en_off_ch1", pwm_out, 3'b101);
    en = 3'b111;
    @(negedge CLK);
    chk("en_back_on", pwm_out, 3'b111);
    repeat (7) @(negedge CLK);
    chk("cnt9_pwm", pwm_out, 3'b101);
    RST_N = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_out, 3'b000);
    chk("async_rst_tick", period_tick, 0);

    // Triangle fade from reset
    mode = 2'b10;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      chk($sformatf("tri_level_k%0d", k), level, tri_tab[k/3]);
    end
    @(negedge CLK);
    measure(-1, 2'd0, h0, h1, h2, t);
    chk("tri_p1_ch0", h0, 4);
    chk("tri_p1_ch1", h1, 8);
    chk("tri_p1_ch2", h2, 4);
    measure(-1, 2'd0, h0, h1, h2, t);
    chk("tri_p2_ch0", h0, 8);
    chk("tri_p2_ch1", h1, 4);
    chk("tri_p2_ch2", h2, 8);
    chk("tri_level_k48", level, tri_tab[16]);
    measure(-1, 2'd0, h0, h1, h2, t);
    chk("tri_p3_ch0", h0, 12);
    chk("tri_p3_ch1", h1, 0);
    chk("tri_p3_ch2", h2, 12);

    // Sawtooth, then hold, then sawtooth again
    RST_N = 1'b0;
    mode  = 2'b01;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      chk($sformatf("saw_level_k%0d", k), level, (k / 3) % 4);
    end
    mode = 2'b11;
    bad = 0;
    for (int k = 19; k <= 39; k++) begin
      @(negedge CLK);
      if (level !== 2'd2) bad++;
    end
    chk("hold_level_changes", bad, 0);
    mode = 2'b01;
    for (int k = 40; k <= 42; k++) begin
      @(negedge CLK);
      chk($sformatf("resume_level_k%0d", k), level, (k == 42) ? 3 : 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
